serial_mul_gen: RTL and testbench

Parametrised successor to the team's radix-2 serial multiplier. Computes the full 2*WIDTH-bit product of two WIDTH-bit operands, retiring BPC multiplier bits per clock. Signed or unsigned mode is selectable per transaction. Sits between two independent operand producers and one result consumer; each link uses a valid/ready handshake, and the result register holds under backpressure.

---
 rtl/serial_mul_pkg.sv | 18 +
 rtl/serial_mul_step.sv | 26 ++
 rtl/serial_mul_gen.sv | 125 ++++++++++++
 tb/tb_serial_mul_gen.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/serial_mul_pkg.sv
// Shared types and elaboration helpers for the parametrised serial multiplier.
package serial_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COMP = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nstep(input int width, input int bpc);
    return width / bpc;
  endfunction

  function automatic bit cfg_ok(input int width, input int bpc);
    return (width >= 2) && ((bpc == 1) || (bpc == 2) || (bpc == 4)) && ((width % bpc) == 0);
  endfunction

endpackage

// File: rtl/serial_mul_step.sv
// One serial step: BPC-bit partial product of the extended multiplicand added to the running sum.
module serial_mul_step #(
  parameter int WIDTH = 32,
  parameter int BPC   = 1
) (
  input  logic [2*WIDTH-1:0] xe,
  input  logic [BPC-1:0]     ybits,
  input  logic               is_signed,
  input  logic               last,
  input  logic [2*WIDTH-1:0] acc,
  output logic [2*WIDTH-1:0] sum
);

  localparam int PW = 2 * WIDTH;

  logic signed [BPC:0]    chunk;
  logic signed [PW-1:0]   chunk_ext;
  logic signed [PW-1:0]   pp;

  // The top chunk of a signed multiplier carries the negative MSB weight.
  assign chunk     = {is_signed & last & ybits[BPC-1], ybits};
  assign chunk_ext = {{(PW-BPC-1){chunk[BPC]}}, chunk};
  assign pp        = $signed(xe) * chunk_ext;
  assign sum       = acc + pp;

endmodule

// File: rtl/serial_mul_gen.sv
// Serial WIDTH x WIDTH multiplier retiring BPC multiplier bits per clock, valid/ready on all links.
// Optional MAC mode under SERIAL_MUL_ACCUM_EN. States: IDLE capture | COMP step | DONE hold result.
module serial_mul_gen #(
  parameter int WIDTH = 32,
  parameter int BPC   = 1
) (
  input  logic                 clk,
  input  logic                 asyn_reset,
  input  logic [WIDTH-1:0]     x,
  input  logic                 x_signed,
`ifdef SERIAL_MUL_ACCUM_EN
  input  logic                 acc_clr,
`endif
  input  logic                 data_x_vld,
  output logic                 data_x_rdy,
  input  logic [WIDTH-1:0]     y,
  input  logic                 data_y_vld,
  output logic                 data_y_rdy,
  output logic [2*WIDTH-1:0]   product,
  output logic                 d_out_vld,
  input  logic                 d_out_rdy,
  output logic                 busy
);
  import serial_mul_pkg::*;

  localparam int NSTEP = nstep(WIDTH, BPC);
  localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam int PW    = 2 * WIDTH;

  if (!cfg_ok(WIDTH, BPC)) begin : g_cfg_check
    $error("serial_mul_gen: WIDTH must be >= 2 and a multiple of BPC, BPC in {1,2,4}");
  end

  state_t           state;
  logic             have_x, have_y, sgn;
  logic [PW-1:0]    x_sh, acc, sum;
  logic [WIDTH-1:0] y_sh;
  logic [CW-1:0]    cnt;
  logic             hs_x, hs_y, last;
`ifdef SERIAL_MUL_ACCUM_EN
  logic             clr;
`endif

  assign data_x_rdy = (state == IDLE) && !have_x;
  assign data_y_rdy = (state == IDLE) && !have_y;
  assign busy       = (state != IDLE);
  assign hs_x       = data_x_vld & data_x_rdy;
  assign hs_y       = data_y_vld & data_y_rdy;
  assign last       = (cnt == '0);

  serial_mul_step #(.WIDTH(WIDTH), .BPC(BPC)) u_step (
    .xe        (x_sh),
    .ybits     (y_sh[BPC-1:0]),
    .is_signed (sgn),
    .last      (last),
    .acc       (acc),
    .sum       (sum)
  );

  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      state     <= IDLE;
      have_x    <= 1'b0;
      have_y    <= 1'b0;
      sgn       <= 1'b0;
      x_sh      <= '0;
      y_sh      <= '0;
      acc       <= '0;
      cnt       <= '0;
      product   <= '0;
      d_out_vld <= 1'b0;
`ifdef SERIAL_MUL_ACCUM_EN
      clr       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // Multiplicand is pre-extended so later steps just shift it left.
          if (hs_x) begin
            x_sh   <= x_signed ? {{WIDTH{x[WIDTH-1]}}, x} : {{WIDTH{1'b0}}, x};
            sgn    <= x_signed;
            have_x <= 1'b1;
`ifdef SERIAL_MUL_ACCUM_EN
            clr    <= acc_clr;
`endif
          end
          if (hs_y) begin
            y_sh   <= y;
            have_y <= 1'b1;
          end
          if (have_x && have_y) begin
            state  <= COMP;
            cnt    <= CW'(NSTEP - 1);
            have_x <= 1'b0;
            have_y <= 1'b0;
`ifdef SERIAL_MUL_ACCUM_EN
            acc    <= clr ? '0 : product;
`else
            acc    <= '0;
`endif
          end
        end
        COMP: begin
          acc  <= sum;
          x_sh <= x_sh << BPC;
          y_sh <= y_sh >> BPC;
          cnt  <= cnt - 1'b1;
          if (last) begin
            state     <= DONE;
            product   <= sum;
            d_out_vld <= 1'b1;
          end
        end
        DONE: begin
          if (d_out_rdy) begin
            state     <= IDLE;
            d_out_vld <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mul_gen.sv
// Randomized and directed bench for serial_mul_gen against an arithmetic reference model.
module tb_serial_mul_gen;
  localparam int W     = 8;
  localparam int BPC   = 2;
  localparam int NSTEP = W / BPC;
  localparam int PW    = 2 * W;

  logic          clk = 1'b0;
  logic          asyn_reset;
  logic [W-1:0]  x, y;
  logic          x_signed, acc_clr;
  logic          data_x_vld, data_x_rdy, data_y_vld, data_y_rdy;
  logic [PW-1:0] product;
  logic          d_out_vld, d_out_rdy, busy;

  int checks   = 0;
  int failures = 0;
  logic [PW-1:0] prev_prod = '0;

  serial_mul_gen #(.WIDTH(W), .BPC(BPC)) dut (
    .clk        (clk),
    .asyn_reset (asyn_reset),
    .x          (x),
    .x_signed   (x_signed),
`ifdef SERIAL_MUL_ACCUM_EN
    .acc_clr    (acc_clr),
`endif
    .data_x_vld (data_x_vld),
    .data_x_rdy (data_x_rdy),
    .y          (y),
    .data_y_vld (data_y_vld),
    .data_y_rdy (data_y_rdy),
    .product    (product),
    .d_out_vld  (d_out_vld),
    .d_out_rdy  (d_out_rdy),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic sgn);
    logic signed [PW-1:0] sa, sb;
    logic [PW-1:0] p;
    if (sgn) begin
      sa = {{W{a[W-1]}}, a};
      sb = {{W{b[W-1]}}, b};
      p  = sa * sb;
    end else begin
      p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    end
    return p;
  endfunction

  task automatic offer(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                       input logic clr, input int dx, input int dy);
    bit tx = 0;
    bit ty = 0;
    int cyc = 0;
    while (!(tx && ty) && cyc < 100) begin
      @(negedge clk);
      if (ty && !tx) chk("y_rdy_held_low", data_y_rdy, 0);
      if (tx && !ty) chk("x_rdy_held_low", data_x_rdy, 0);
      data_x_vld = !tx && (cyc >= dx);
      x          = data_x_vld ? a : W'($urandom);
      x_signed   = data_x_vld ? sgn : 1'($urandom);
      acc_clr    = data_x_vld ? clr : 1'($urandom);
      data_y_vld = !ty && (cyc >= dy);
      y          = data_y_vld ? b : W'($urandom);
      if (data_x_vld && data_x_rdy) tx = 1;
      if (data_y_vld && data_y_rdy) ty = 1;
      cyc++;
    end
    if (!(tx && ty)) chk("handshake_timeout", 0, 1);
  endtask

  task automatic finish(input logic [PW-1:0] exp, input int hold, input string tag);
    int n = 0;
    bit blocked = 1;
    d_out_rdy = (hold == 0);
    do begin
      @(negedge clk);
      n++;
      // Junk operands offered while busy must not be taken.
      data_x_vld = 1'b1;
      data_y_vld = 1'b1;
      x = W'($urandom);
      y = W'($urandom);
      if (data_x_rdy || data_y_rdy) blocked = 0;
    end while (!d_out_vld && n < 4 * NSTEP + 20);
    data_x_vld = 1'b0;
    data_y_vld = 1'b0;
    chk({tag, "_latency"}, 64'(n - 1), 64'(NSTEP + 1));
    chk({tag, "_blocked"}, 64'(blocked), 1);
    for (int i = 0; i < hold; i++) begin
      chk({tag, "_hold_prod"}, product, exp);
      chk({tag, "_hold_vld_rdys"}, {d_out_vld, data_x_rdy, data_y_rdy}, 3'b100);
      @(negedge clk);
    end
    chk({tag, "_product"}, product, exp);
    d_out_rdy = 1'b1;
    @(negedge clk);
    d_out_rdy = 1'b0;
    chk({tag, "_idle_flags"}, {d_out_vld, data_x_rdy, data_y_rdy, busy}, 4'b0110);
    chk({tag, "_prod_kept"}, product, exp);
    prev_prod = exp;
  endtask

  task automatic txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                     input logic clr, input int dx, input int dy, input int hold,
                     input logic [PW-1:0] exp, input string tag);
    offer(a, b, sgn, clr, dx, dy);
    finish(exp, hold, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    logic [W-1:0] a, b;
    logic sgn, clr;
    logic [PW-1:0] exp;
    asyn_reset = 1'b1;
    x = '0; y = '0; x_signed = 1'b0; acc_clr = 1'b1;
    data_x_vld = 1'b0; data_y_vld = 1'b0; d_out_rdy = 1'b0;
    repeat (3) @(negedge clk);
    asyn_reset = 1'b0;
    chk("reset_state", {product, d_out_vld, busy, data_x_rdy, data_y_rdy}, {16'h0000, 4'b0011});

    txn(8'd13, 8'd11, 1'b0, 1'b1, 0, 0, 0, 16'h008F, "u13x11");
    txn(8'd255, 8'd255, 1'b0, 1'b1, 0, 0, 2, 16'hFE01, "u255sq");
    txn(8'hFD, 8'h05, 1'b1, 1'b1, 1, 0, 0, 16'hFFF1, "s_m3x5");
    txn(8'h80, 8'h80, 1'b1, 1'b1, 0, 2, 0, 16'h4000, "s_m128sq");
    txn(8'd21, 8'd6, 1'b0, 1'b1, 3, 0, 0, 16'd126, "y_early");
    txn(8'hF0, 8'd7, 1'b1, 1'b1, 0, 0, 10, 16'hFF90, "hold10");

    // Reset in the middle of COMP: transaction discarded.
    offer(8'd100, 8'd200, 1'b0, 1'b1, 0, 0);
    @(negedge clk);
    data_x_vld = 1'b0;
    data_y_vld = 1'b0;
    repeat (3) @(negedge clk);
    #2 asyn_reset = 1'b1;
    #1 chk("midrst_outputs", {product, d_out_vld, busy}, {16'h0000, 2'b00});
    @(negedge clk);
    asyn_reset = 1'b0;
    prev_prod = '0;
    seen = 0;
    repeat (3 * NSTEP) begin
      @(negedge clk);
      if (d_out_vld) seen = 1;
    end
    chk("midrst_no_vld", 64'(seen), 0);
    txn(8'd7, 8'd9, 1'b0, 1'b1, 0, 0, 0, 16'h003F, "after_rst");

`ifdef SERIAL_MUL_ACCUM_EN
    txn(8'd2, 8'd3, 1'b0, 1'b1, 0, 0, 0, 16'd6, "mac_first");
    txn(8'd4, 8'd5, 1'b0, 1'b0, 0, 0, 0, 16'd26, "mac_second");
`endif

    for (int i = 0; i < 40; i++) begin
      a   = W'($urandom);
      b   = W'($urandom);
      sgn = 1'($urandom);
      clr = ($urandom_range(0, 3) == 0);
      exp = ref_mul(a, b, sgn);
`ifdef SERIAL_MUL_ACCUM_EN
      if (!clr) exp = exp + prev_prod;
`endif
      txn(a, b, sgn, clr, $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 3), exp, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
